fetch_queue: RTL and testbench

Parametrised instruction-fetch unit with a halfword-parcel prefetch queue between instruction memory and decode. It decouples memory latency from decode stalls, reassembles 16/32-bit instructions (optional C extension) across word boundaries, and flushes on taken branches. It sits where the IF stage sits: memory request side upstream, ID valid/ready handshake downstream.

---
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 151 +++++++++++++++
 tb/tb_fetch_queue.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-unit bus bundle: instruction-memory request side, branch redirect and ID handshake.
// The master modport is the fetch unit; the slave modport is the memory/decode environment.
interface fetch_queue_if;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic        i_br_en;
    logic [31:0] i_br_addr;
    logic        o_id_valid;
    logic        i_id_ready;
    logic [31:0] o_id_ir;
    logic [31:0] o_id_pc;
    logic [31:0] o_id_ret;

    modport master (
        output o_mem_req, o_mem_addr,
        input  i_mem_ack, i_mem_data,
        input  i_br_en, i_br_addr,
        output o_id_valid, o_id_ir, o_id_pc, o_id_ret,
        input  i_id_ready
    );

    modport slave (
        input  o_mem_req, o_mem_addr,
        output i_mem_ack, i_mem_data,
        output i_br_en, i_br_addr,
        input  o_id_valid, o_id_ir, o_id_pc, o_id_ret,
        output i_id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit: one-outstanding word fetcher feeding a halfword-parcel queue,
// with 16/32-bit instruction reassembly at the head and branch flush/redirect.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 8,
    parameter int          C_EXT    = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_ce,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [15:0]   par_q [QDEPTH];
    logic [31:0]   adr_q [QDEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   r_addr_q, r_addr_d;
    logic [31:0]   f_pc_q, f_pc_d;
    logic          discard_q, discard_d;

    logic [PW-1:0] rd_ptr_nx;
    logic [PW-1:0] wr_ptr_nx;
    logic [15:0]   p0, p1;
    logic [31:0]   a0;
    logic          is_c;
    logic          head_valid;
    logic          ack;
    logic          push, pop;
    logic [CW-1:0] push_n, pop_n;
    logic          req_next;
    logic [31:0]   target;
    logic          unused_br_bit0;

    assign unused_br_bit0 = bus.i_br_addr[0];

    assign rd_ptr_nx = rd_ptr_q + 1'b1;
    assign wr_ptr_nx = wr_ptr_q + 1'b1;
    assign p0 = par_q[rd_ptr_q];
    assign p1 = par_q[rd_ptr_nx];
    assign a0 = adr_q[rd_ptr_q];

    assign is_c       = (C_EXT != 0) && (p0[1:0] != 2'b11);
    assign head_valid = is_c ? (count_q != '0) : (count_q >= CW'(2));

    assign bus.o_id_valid = head_valid;
    assign bus.o_id_ir    = !head_valid ? 32'h0 : (is_c ? {16'h0, p0} : {p1, p0});
    assign bus.o_id_pc    = head_valid ? a0 : 32'h0;
    assign bus.o_id_ret   = head_valid ? (a0 + (is_c ? 32'd2 : 32'd4)) : 32'h0;
    assign bus.o_mem_req  = mem_req_q;
    assign bus.o_mem_addr = mem_addr_q;

    // A redirect overrides any same-cycle push or pop
    assign ack    = mem_req_q && bus.i_mem_ack;
    assign push   = ack && !discard_q && !bus.i_br_en;
    assign pop    = head_valid && bus.i_id_ready && !bus.i_br_en;
    assign push_n = r_addr_q[1] ? CW'(1) : CW'(2);
    assign pop_n  = is_c ? CW'(1) : CW'(2);
    assign target = {bus.i_br_addr[31:2], (C_EXT != 0) ? bus.i_br_addr[1] : 1'b0, 1'b0};

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        r_addr_d   = r_addr_q;
        f_pc_d     = f_pc_q;
        discard_d  = discard_q;

        if (bus.i_br_en) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(push_n);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(pop_n);
            count_d = count_q + (push ? push_n : '0) - (pop ? pop_n : '0);
        end

        // Room for a whole word must remain after this edge before asking for another
        req_next = (count_d <= CW'(QDEPTH - 2));

        if (bus.i_br_en) begin
            if (mem_req_q && !ack) begin
                discard_d = 1'b1;
                f_pc_d    = target;
            end else begin
                discard_d  = 1'b0;
                mem_req_d  = 1'b1;
                r_addr_d   = target;
                mem_addr_d = {target[31:2], 2'b00};
                f_pc_d     = {target[31:2] + 30'd1, 2'b00};
            end
        end else begin
            if (ack) begin
                discard_d = 1'b0;
                mem_req_d = 1'b0;
            end
            if (req_next && (!mem_req_q || ack)) begin
                mem_req_d  = 1'b1;
                r_addr_d   = f_pc_q;
                mem_addr_d = {f_pc_q[31:2], 2'b00};
                f_pc_d     = {f_pc_q[31:2] + 30'd1, 2'b00};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            r_addr_q   <= 32'h0;
            f_pc_q     <= RESET_PC;
            discard_q  <= 1'b0;
        end else if (i_clk_ce) begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            r_addr_q   <= r_addr_d;
            f_pc_q     <= f_pc_d;
            discard_q  <= discard_d;
        end
    end

    // A request starting mid-word (bit 1 set) only yields its upper parcel
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_clk_ce && push) begin
            if (r_addr_q[1]) begin
                par_q[wr_ptr_q] <= bus.i_mem_data[31:16];
                adr_q[wr_ptr_q] <= r_addr_q;
            end else begin
                par_q[wr_ptr_q]  <= bus.i_mem_data[15:0];
                adr_q[wr_ptr_q]  <= r_addr_q;
                par_q[wr_ptr_nx] <= bus.i_mem_data[31:16];
                adr_q[wr_ptr_nx] <= r_addr_q + 32'd2;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: word memory model with gated acks, hand-computed
// expectations checked 1 time unit after each rising edge.
module tb_fetch_queue;
    logic        clk;
    logic        rst;
    logic        ce;
    logic        ack_en;
    logic [31:0] mem [256];
    int          checks;
    int          failures;

    fetch_queue_if bus ();

    fetch_queue #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (8),
        .C_EXT    (1)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clk_ce (ce),
        .bus      (bus)
    );

    assign bus.i_mem_ack  = ack_en & bus.o_mem_req;
    assign bus.i_mem_data = mem[bus.o_mem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_default();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 + (32'(i) << 20);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; ce = 1'b1; ack_en = 1'b0;
        bus.i_id_ready = 1'b0; bus.i_br_en = 1'b0; bus.i_br_addr = 32'h0;
        fill_default();
        tick(); tick();
        chk("rst_req",   {31'b0, bus.o_mem_req}, 32'd0);
        chk("rst_addr",  bus.o_mem_addr, 32'h0);
        chk("rst_valid", {31'b0, bus.o_id_valid}, 32'd0);
        chk("rst_ir",    bus.o_id_ir, 32'h0);
        chk("rst_pc",    bus.o_id_pc, 32'h0);
        chk("rst_ret",   bus.o_id_ret, 32'h0);

        // 32-bit stream, one word per cycle
        rst = 1'b0; ack_en = 1'b1; bus.i_id_ready = 1'b1;
        tick();
        chk("a_req",    {31'b0, bus.o_mem_req}, 32'd1);
        chk("a_addr0",  bus.o_mem_addr, 32'h0);
        chk("a_valid0", {31'b0, bus.o_id_valid}, 32'd0);
        tick();
        chk("a_addr4",  bus.o_mem_addr, 32'h4);
        chk("a_pc0",    bus.o_id_pc, 32'h0);
        chk("a_ret0",   bus.o_id_ret, 32'h4);
        chk("a_ir0",    bus.o_id_ir, 32'h0000_0013);
        tick();
        chk("a_addr8",  bus.o_mem_addr, 32'h8);
        chk("a_pc4",    bus.o_id_pc, 32'h4);
        chk("a_ret4",   bus.o_id_ret, 32'h8);
        chk("a_ir4",    bus.o_id_ir, 32'h0010_0013);
        tick();
        chk("a_pc8",    bus.o_id_pc, 32'h8);
        chk("a_ret8",   bus.o_id_ret, 32'hC);

        // compressed pair then 32-bit op
        rst = 1'b1; mem[0] = 32'h0505_0001;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("b_ir0",  bus.o_id_ir, 32'h0000_0001);
        chk("b_pc0",  bus.o_id_pc, 32'h0);
        chk("b_ret0", bus.o_id_ret, 32'h2);
        tick();
        chk("b_ir2",  bus.o_id_ir, 32'h0000_0505);
        chk("b_pc2",  bus.o_id_pc, 32'h2);
        chk("b_ret2", bus.o_id_ret, 32'h4);
        tick();
        chk("b_ir4",  bus.o_id_ir, 32'h0010_0013);
        chk("b_pc4",  bus.o_id_pc, 32'h4);
        chk("b_ret4", bus.o_id_ret, 32'h8);

        // 32-bit op at 0x6 spanning words 0x4/0x8, word 0x8 delayed
        rst = 1'b1;
        mem[0] = 32'h0001_0001; mem[1] = 32'h0093_0001; mem[2] = 32'h0001_0010;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        tick();
        chk("c_pc2", bus.o_id_pc, 32'h2);
        ack_en = 1'b0;
        tick();
        chk("c_pc4",   bus.o_id_pc, 32'h4);
        chk("c_req",   {31'b0, bus.o_mem_req}, 32'd1);
        chk("c_addr8", bus.o_mem_addr, 32'h8);
        tick();
        chk("c_valid_wait", {31'b0, bus.o_id_valid}, 32'd0);
        chk("c_ir_wait",    bus.o_id_ir, 32'h0);
        tick();
        chk("c_valid_wait2", {31'b0, bus.o_id_valid}, 32'd0);
        chk("c_addr_hold",   bus.o_mem_addr, 32'h8);
        ack_en = 1'b1;
        tick();
        chk("c_valid", {31'b0, bus.o_id_valid}, 32'd1);
        chk("c_ir",    bus.o_id_ir, 32'h0010_0093);
        chk("c_pc6",   bus.o_id_pc, 32'h6);
        chk("c_retA",  bus.o_id_ret, 32'hA);

        // decode stalled: queue fills, requests stop, head held
        rst = 1'b1; fill_default(); bus.i_id_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        chk("d_req_e4",  {31'b0, bus.o_mem_req}, 32'd1);
        chk("d_addr_e4", bus.o_mem_addr, 32'hC);
        tick();
        chk("d_req_full", {31'b0, bus.o_mem_req}, 32'd0);
        chk("d_pc_hold",  bus.o_id_pc, 32'h0);
        repeat (5) tick();
        chk("d_req_still", {31'b0, bus.o_mem_req}, 32'd0);
        chk("d_valid",     {31'b0, bus.o_id_valid}, 32'd1);
        chk("d_ir_hold",   bus.o_id_ir, 32'h0000_0013);
        chk("d_pc_hold2",  bus.o_id_pc, 32'h0);
        bus.i_id_ready = 1'b1; ack_en = 1'b0;
        tick();
        chk("d_req_resume", {31'b0, bus.o_mem_req}, 32'd1);
        chk("d_addr_10",    bus.o_mem_addr, 32'h10);
        chk("d_pc4",        bus.o_id_pc, 32'h4);

        // branch to 0x102 while 0x10 is pending; late ack is dropped
        mem[64] = 32'h0001_DEAD;
        bus.i_br_en = 1'b1; bus.i_br_addr = 32'h102;
        tick();
        bus.i_br_en = 1'b0;
        chk("e_valid_flush", {31'b0, bus.o_id_valid}, 32'd0);
        chk("e_req_pend",    {31'b0, bus.o_mem_req}, 32'd1);
        chk("e_addr_pend",   bus.o_mem_addr, 32'h10);
        tick(); tick();
        chk("e_valid_wait", {31'b0, bus.o_id_valid}, 32'd0);
        chk("e_addr_wait",  bus.o_mem_addr, 32'h10);
        ack_en = 1'b1;
        tick();
        chk("e_addr_100",  bus.o_mem_addr, 32'h100);
        chk("e_valid_drop", {31'b0, bus.o_id_valid}, 32'd0);
        tick();
        chk("e_valid", {31'b0, bus.o_id_valid}, 32'd1);
        chk("e_pc",    bus.o_id_pc, 32'h102);
        chk("e_ir",    bus.o_id_ir, 32'h0000_0001);
        chk("e_ret",   bus.o_id_ret, 32'h104);
        chk("e_addr",  bus.o_mem_addr, 32'h104);

        // branch coincident with ack and pop; target bit 0 cleared
        mem[130] = 32'h0093_0001; mem[131] = 32'h0000_0010;
        bus.i_br_en = 1'b1; bus.i_br_addr = 32'h20B;
        tick();
        bus.i_br_en = 1'b0; ack_en = 1'b0;
        chk("f_valid", {31'b0, bus.o_id_valid}, 32'd0);
        chk("f_addr",  bus.o_mem_addr, 32'h208);
        chk("f_req",   {31'b0, bus.o_mem_req}, 32'd1);
        tick();
        chk("f_empty", {31'b0, bus.o_id_valid}, 32'd0);
        ack_en = 1'b1;
        tick();
        chk("f_half_only", {31'b0, bus.o_id_valid}, 32'd0);
        chk("f_addr_20c",  bus.o_mem_addr, 32'h20C);
        tick();
        chk("f_ir",   bus.o_id_ir, 32'h0010_0093);
        chk("f_pc",   bus.o_id_pc, 32'h20A);
        chk("f_ret",  bus.o_id_ret, 32'h20E);
        chk("f_addr_210", bus.o_mem_addr, 32'h210);

        // clock enable low freezes state and ignores ack
        ce = 1'b0;
        tick();
        chk("g_pc_frozen",   bus.o_id_pc, 32'h20A);
        chk("g_addr_frozen", bus.o_mem_addr, 32'h210);
        ce = 1'b1;
        tick();
        chk("g_pc_next",  bus.o_id_pc, 32'h20E);
        chk("g_ret_next", bus.o_id_ret, 32'h210);
        chk("g_addr_214", bus.o_mem_addr, 32'h214);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
